// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    localparam int          PC_STEP   = 2;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/fetch_if.sv
// Bundle of the fetch stage's memory, redirect and decoder handshakes.
// "master" is the fetch unit's view, "slave" is the surrounding system.
interface fetch_if #(
    parameter int PC_WIDTH = 16
);

    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [PC_WIDTH-1:0] imem_req_addr;
    logic                imem_resp_valid;
    logic [15:0]         imem_resp_data;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                instr_valid;
    logic                instr_ready;
    logic [15:0]         instruction;
    logic [PC_WIDTH-1:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small instruction buffer holding {pc, instruction} pairs in fetch order.
// Head entry is read straight from storage, so a push becomes visible on
// the next cycle.
module fetch_fifo #(
    parameter int DEPTH    = 2,
    parameter int PC_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      clear,
    input  logic [PC_WIDTH-1:0]       push_pc,
    input  logic [15:0]               push_instr,
    output logic [PC_WIDTH-1:0]       head_pc,
    output logic [15:0]               head_instr,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
    logic [15:0]         instr_mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;

    // Pointers and occupancy; clear empties the buffer in one cycle.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (reset && push && !clear) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];
    assign full       = (count == (PW+1)'(DEPTH));
    assign empty      = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, credit-limited request issue,
// in-order response tracking and redirect flushing in front of the decoder.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  DEPTH    = 2
) (
    input  logic   clk,
    input  logic   reset,
    fetch_if.master bus
);

    localparam int                  CW       = $clog2(DEPTH) + 1;
    localparam int                  PW       = $clog2(DEPTH);
    localparam logic [PC_WIDTH-1:0] START_PC = RESET_PC & ~PC_WIDTH'(1);

    fetch_state_t        state;
    logic [PC_WIDTH-1:0] pc;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       drop;

    // Addresses of requests still waiting for their response.
    logic [PC_WIDTH-1:0] pcq [DEPTH];
    logic [PW-1:0]       pcq_wr;
    logic [PW-1:0]       pcq_rd;

    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic [PC_WIDTH-1:0] head_pc;
    logic [15:0]         head_instr;

    logic [CW:0]         in_use;
    logic                req_valid;
    logic                accept;
    logic                resp;
    logic                fifo_push;
    logic                fifo_pop;
    logic [CW-1:0]       out_after;
    logic [CW-1:0]       drop_after;
    logic [PC_WIDTH-1:0] resp_pc;
    logic [PC_WIDTH-1:0] target_pc;

    // Credit check, handshakes and next-count arithmetic for this cycle.
    always_comb begin
        in_use     = {1'b0, outstanding} + {1'b0, fifo_count};
        req_valid  = (state == FETCH) && (in_use < (CW+1)'(DEPTH)) && !bus.redirect_valid;
        accept     = req_valid && bus.imem_req_ready;
        resp       = bus.imem_resp_valid && (state != IDLE);
        out_after  = outstanding + CW'(accept) - CW'(resp);
        drop_after = drop - CW'(resp);
        fifo_push  = (state == FETCH) && resp && !bus.redirect_valid;
        fifo_pop   = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;
        // A response with nothing recorded outstanding answers this cycle's request.
        resp_pc    = (outstanding == '0) ? pc : pcq[pcq_rd];
        target_pc  = bus.redirect_pc & ~PC_WIDTH'(1);
    end

    // Control FSM with PC register and outstanding/drop counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= START_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= out_after;
            if (bus.redirect_valid) begin
                pc    <= target_pc;
                drop  <= out_after;
                state <= (out_after != '0) ? FLUSH : FETCH;
            end else begin
                case (state)
                    IDLE: state <= FETCH;
                    FETCH: begin
                        if (accept) pc <= pc + PC_WIDTH'(PC_STEP);
                    end
                    FLUSH: begin
                        drop <= drop_after;
                        if (drop_after == '0) state <= FETCH;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Side queue pairing each in-order response with its request address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pcq_wr <= '0;
            pcq_rd <= '0;
        end else begin
            if (accept) begin
                pcq[pcq_wr] <= pc;
                pcq_wr      <= pcq_wr + PW'(1);
            end
            if (resp) pcq_rd <= pcq_rd + PW'(1);
        end
    end

    fetch_fifo #(
        .DEPTH    (DEPTH),
        .PC_WIDTH (PC_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .clear      (bus.redirect_valid),
        .push_pc    (resp_pc),
        .push_instr (bus.imem_resp_data),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.instr_valid    = !fifo_empty;
    assign bus.instruction    = fifo_empty ? NOP_INSTR : head_instr;
    assign bus.instr_pc       = fifo_empty ? START_PC : head_pc;

    // The credit rule must keep the buffer from ever overflowing.
    assert property (@(posedge clk) disable iff (!reset) !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with an in-order memory model that
// answers in the same cycle when idle and can be held to build up
// outstanding requests.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] next_pc;

    always #5 clk = ~clk;

    fetch_if #(.PC_WIDTH(16)) bus();

    fetch_unit #(
        .PC_WIDTH (16),
        .RESET_PC (16'h0000),
        .DEPTH    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory returns a word derived from the address so data and pc differ.
    function automatic logic [15:0] resp_word(input logic [15:0] a);
        return a ^ 16'h5A00;
    endfunction

    logic        mem_hold;
    logic [15:0] mq [8];
    int          mq_cnt;
    logic        mq_pop;
    logic        mq_push;

    // Memory response: oldest queued request first, else same-cycle answer.
    always_comb begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 16'h0000;
        mq_pop  = 1'b0;
        mq_push = 1'b0;
        if (!mem_hold && mq_cnt != 0) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = resp_word(mq[0]);
            mq_pop = 1'b1;
        end else if (!mem_hold && bus.imem_req_valid && bus.imem_req_ready) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = resp_word(bus.imem_req_addr);
        end
        mq_push = bus.imem_req_valid && bus.imem_req_ready && !(!mem_hold && mq_cnt == 0);
    end

    // Memory request queue, reset together with the fetch unit.
    always @(posedge clk) begin
        if (!reset) begin
            mq_cnt <= 0;
        end else begin
            if (mq_pop) for (int i = 0; i < 7; i++) mq[i] <= mq[i+1];
            if (mq_push) mq[mq_cnt - (mq_pop ? 1 : 0)] <= bus.imem_req_addr;
            mq_cnt <= mq_cnt + (mq_push ? 1 : 0) - (mq_pop ? 1 : 0);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) cycle();
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid);
        end
        checks++;
        if (bus.imem_req_addr !== 16'h0000) begin
            errors++; $display("[TB] FAIL reset_req_addr: got %h expected 0000", bus.imem_req_addr);
        end
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_instr_valid: got %b expected 0", bus.instr_valid);
        end
        checks++;
        if (bus.instruction !== NOP_INSTR) begin
            errors++; $display("[TB] FAIL reset_instruction: got %h expected %h", bus.instruction, NOP_INSTR);
        end
        checks++;
        if (bus.instr_pc !== 16'h0000) begin
            errors++; $display("[TB] FAIL reset_instr_pc: got %h expected 0000", bus.instr_pc);
        end
    endtask

    task automatic test_startup_stream();
        int n = 0;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_no_request: got %b expected 0", bus.imem_req_valid);
        end
        cycle();
        checks++;
        if ({bus.imem_req_valid, bus.imem_req_addr, bus.instr_valid} !== {1'b1, 16'h0000, 1'b0}) begin
            errors++; $display("[TB] FAIL first_request: got v=%b a=%h iv=%b expected v=1 a=0000 iv=0",
                               bus.imem_req_valid, bus.imem_req_addr, bus.instr_valid);
        end
        cycle();
        checks++;
        if (bus.instr_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL first_instr_latency: got %b expected 1", bus.instr_valid);
        end
        next_pc = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            if (bus.instr_valid && bus.instr_ready) begin
                checks++;
                if ({bus.instr_pc, bus.instruction} !== {next_pc, resp_word(next_pc)}) begin
                    errors++; $display("[TB] FAIL stream_order: got pc=%h ins=%h expected pc=%h ins=%h",
                                       bus.instr_pc, bus.instruction, next_pc, resp_word(next_pc));
                end
                next_pc = next_pc + 16'd2;
                n++;
            end
            cycle();
        end
        checks++;
        if (n !== 8) begin
            errors++; $display("[TB] FAIL stream_throughput: got %0d expected 8", n);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if ({bus.imem_req_valid, bus.instr_valid, bus.instr_pc} !== {1'b0, 1'b1, next_pc}) begin
                errors++; $display("[TB] FAIL backpressure_hold: got rv=%b iv=%b pc=%h expected rv=0 iv=1 pc=%h",
                                   bus.imem_req_valid, bus.instr_valid, bus.instr_pc, next_pc);
            end
        end
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus.instr_valid && bus.instr_ready) begin
                checks++;
                if ({bus.instr_pc, bus.instruction} !== {next_pc, resp_word(next_pc)}) begin
                    errors++; $display("[TB] FAIL backpressure_order: got pc=%h ins=%h expected pc=%h ins=%h",
                                       bus.instr_pc, bus.instruction, next_pc, resp_word(next_pc));
                end
                next_pc = next_pc + 16'd2;
                n++;
            end
            cycle();
        end
        checks++;
        if (n !== 8) begin
            errors++; $display("[TB] FAIL backpressure_release: got %0d expected 8", n);
        end
    endtask

    task automatic test_req_stall();
        int n = 0;
        logic [15:0] stall_addr;
        stall_addr = next_pc + 16'd2;
        bus.imem_req_ready = 1'b0;
        checks++;
        if (bus.instr_pc !== next_pc) begin
            errors++; $display("[TB] FAIL stall_head: got %h expected %h", bus.instr_pc, next_pc);
        end
        next_pc = next_pc + 16'd2;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, stall_addr}) begin
                errors++; $display("[TB] FAIL stall_addr_hold: got v=%b a=%h expected v=1 a=%h",
                                   bus.imem_req_valid, bus.imem_req_addr, stall_addr);
            end
        end
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_no_instr: got %b expected 0", bus.instr_valid);
        end
        bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.instr_valid && bus.instr_ready) begin
                checks++;
                if ({bus.instr_pc, bus.instruction} !== {next_pc, resp_word(next_pc)}) begin
                    errors++; $display("[TB] FAIL stall_order: got pc=%h ins=%h expected pc=%h ins=%h",
                                       bus.instr_pc, bus.instruction, next_pc, resp_word(next_pc));
                end
                next_pc = next_pc + 16'd2;
                n++;
            end
            cycle();
        end
        checks++;
        if (n !== 5) begin
            errors++; $display("[TB] FAIL stall_resume: got %0d expected 5", n);
        end
    endtask

    task automatic test_redirect_flush();
        int n = 0;
        mem_hold = 1'b1;
        next_pc = next_pc + 16'd2;
        cycle();
        cycle();
        checks++;
        if ({bus.imem_req_valid, bus.instr_valid} !== 2'b00) begin
            errors++; $display("[TB] FAIL inflight_credit: got rv=%b iv=%b expected 00",
                               bus.imem_req_valid, bus.instr_valid);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0100;
        cycle();
        bus.redirect_valid = 1'b0;
        mem_hold = 1'b0;
        #1;
        checks++;
        if ({bus.imem_req_valid, bus.instr_valid} !== 2'b00) begin
            errors++; $display("[TB] FAIL flush_entry: got rv=%b iv=%b expected 00",
                               bus.imem_req_valid, bus.instr_valid);
        end
        cycle();
        checks++;
        if ({bus.imem_req_valid, bus.instr_valid} !== 2'b00) begin
            errors++; $display("[TB] FAIL flush_one_left: got rv=%b iv=%b expected 00",
                               bus.imem_req_valid, bus.instr_valid);
        end
        cycle();
        checks++;
        if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 16'h0100}) begin
            errors++; $display("[TB] FAIL flush_restart: got v=%b a=%h expected v=1 a=0100",
                               bus.imem_req_valid, bus.imem_req_addr);
        end
        next_pc = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            if (bus.instr_valid && bus.instr_ready) begin
                checks++;
                if ({bus.instr_pc, bus.instruction} !== {next_pc, resp_word(next_pc)}) begin
                    errors++; $display("[TB] FAIL flush_target_order: got pc=%h ins=%h expected pc=%h ins=%h",
                                       bus.instr_pc, bus.instruction, next_pc, resp_word(next_pc));
                end
                next_pc = next_pc + 16'd2;
                n++;
            end
            cycle();
        end
        checks++;
        if (n !== 4) begin
            errors++; $display("[TB] FAIL flush_target_count: got %0d expected 4", n);
        end
    endtask

    task automatic test_redirect_odd();
        int n = 0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0101;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL redirect_blocks_req: got %b expected 0", bus.imem_req_valid);
        end
        cycle();
        bus.redirect_valid = 1'b0;
        #1;
        checks++;
        if ({bus.instr_valid, bus.imem_req_valid, bus.imem_req_addr} !== {1'b0, 1'b1, 16'h0100}) begin
            errors++; $display("[TB] FAIL odd_redirect: got iv=%b rv=%b a=%h expected iv=0 rv=1 a=0100",
                               bus.instr_valid, bus.imem_req_valid, bus.imem_req_addr);
        end
        next_pc = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            if (bus.instr_valid && bus.instr_ready) begin
                checks++;
                if ({bus.instr_pc, bus.instruction} !== {next_pc, resp_word(next_pc)}) begin
                    errors++; $display("[TB] FAIL odd_order: got pc=%h ins=%h expected pc=%h ins=%h",
                                       bus.instr_pc, bus.instruction, next_pc, resp_word(next_pc));
                end
                next_pc = next_pc + 16'd2;
                n++;
            end
            cycle();
        end
        checks++;
        if (n !== 3) begin
            errors++; $display("[TB] FAIL odd_count: got %0d expected 3", n);
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'hFFFC;
        cycle();
        bus.redirect_valid = 1'b0;
        next_pc = 16'hFFFC;
        for (int i = 0; i < 6; i++) begin
            if (bus.instr_valid && bus.instr_ready) begin
                checks++;
                if ({bus.instr_pc, bus.instruction} !== {next_pc, resp_word(next_pc)}) begin
                    errors++; $display("[TB] FAIL wrap_order: got pc=%h ins=%h expected pc=%h ins=%h",
                                       bus.instr_pc, bus.instruction, next_pc, resp_word(next_pc));
                end
                next_pc = next_pc + 16'd2;
                n++;
            end
            cycle();
        end
        checks++;
        if ({n, next_pc} !== {32'd5, 16'h0006}) begin
            errors++; $display("[TB] FAIL wrap_count: got n=%0d next=%h expected n=5 next=0006", n, next_pc);
        end
    endtask

    task automatic test_reset_full();
        int n = 0;
        bus.instr_ready = 1'b0;
        cycle();
        cycle();
        checks++;
        if ({bus.instr_valid, bus.imem_req_valid} !== 2'b10) begin
            errors++; $display("[TB] FAIL full_before_reset: got iv=%b rv=%b expected iv=1 rv=0",
                               bus.instr_valid, bus.imem_req_valid);
        end
        reset = 1'b0;
        cycle();
        checks++;
        if ({bus.instr_valid, bus.imem_req_valid, bus.imem_req_addr, bus.instr_pc} !==
            {1'b0, 1'b0, 16'h0000, 16'h0000}) begin
            errors++; $display("[TB] FAIL reset_when_full: got iv=%b rv=%b a=%h pc=%h expected 0 0 0000 0000",
                               bus.instr_valid, bus.imem_req_valid, bus.imem_req_addr, bus.instr_pc);
        end
        reset = 1'b1;
        bus.instr_ready = 1'b1;
        cycle();
        checks++;
        if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 16'h0000}) begin
            errors++; $display("[TB] FAIL restart_request: got v=%b a=%h expected v=1 a=0000",
                               bus.imem_req_valid, bus.imem_req_addr);
        end
        next_pc = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            if (bus.instr_valid && bus.instr_ready) begin
                checks++;
                if ({bus.instr_pc, bus.instruction} !== {next_pc, resp_word(next_pc)}) begin
                    errors++; $display("[TB] FAIL restart_order: got pc=%h ins=%h expected pc=%h ins=%h",
                                       bus.instr_pc, bus.instruction, next_pc, resp_word(next_pc));
                end
                next_pc = next_pc + 16'd2;
                n++;
            end
            cycle();
        end
        checks++;
        if (n !== 4) begin
            errors++; $display("[TB] FAIL restart_count: got %0d expected 4", n);
        end
    endtask

    initial begin
        reset              = 1'b0;
        mem_hold           = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        next_pc            = 16'h0000;
        $display("[TB] starting fetch_unit tests");
        test_reset();
        test_startup_stream();
        test_backpressure();
        test_req_stall();
        test_redirect_flush();
        test_redirect_odd();
        test_wrap();
        test_reset_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
